// File: rtl/multicycle_cu.sv
// ---------------------------------------------------------------------------
// multicycle_cu -- multi-cycle control unit for the 16-bit CPU.
//
// Sequences every instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB. Memory
// accesses in FETCH and MEM stall on MemReady and are aborted after
// MEM_TIMEOUT idle cycles. Datapath controls are decoded from the state
// register and the opcode latched in DECODE. The exceptions are FETCH
// completion, the BEQ PC write, IllegalOp and MemTimeout, which also depend
// on the current inputs.
//
// Ports:
//   Clock, ResetN            rising-edge clock, async active-low reset
//   OPCODE [OPCODE_W]        opcode from IR, sampled in DECODE
//   Zero                     ALU zero flag (BEQ in EXEC)
//   MemReady                 memory access completes this cycle
//   PCWrite, IRWrite         PC / IR load enables
//   RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUsrc, RegWrite
//                            datapath controls
//   ALUop [ALUOP_W]          00 add, 01 sub/compare, 10 R-type, 11 immediate
//   State [3]                IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5
//   IllegalOp                one-cycle pulse in DECODE on an undefined opcode
//   MemTimeout               one-cycle pulse when an access is aborted
//   InstrCount [CNT_W]       retired-instruction counter (PERF_CNT_EN only)
//
// Optional feature: define PERF_CNT_EN to add the CNT_W parameter and the
// InstrCount output.
// ---------------------------------------------------------------------------
module multicycle_cu #(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W       = 16
`endif
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegDst,
  output logic                Jump,
  output logic                Branch,
  output logic                MemRead,
  output logic                MemToReg,
  output logic                MemWrite,
  output logic                ALUsrc,
  output logic                RegWrite,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic [2:0]          State,
  output logic                IllegalOp,
  output logic                MemTimeout
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    InstrCount
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LW, C_SW, C_J, C_BEQ, C_ILL
  } op_class_t;

  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic [WAIT_W-1:0]   wait_cnt;
  op_class_t           in_cls;   // class of the live OPCODE (DECODE)
  op_class_t           op_cls;   // class of the latched opcode
  logic                timeout;

  // Only the low 4 bits carry the opcode; any set upper bit makes it illegal.
  function automatic op_class_t classify(input logic [OPCODE_W-1:0] op);
    op_class_t cls;
    if ((op >> 4) != '0) begin
      cls = C_ILL;
    end else begin
      case (op[3:0])
        4'b0000, 4'b0001, 4'b0010: cls = C_R;
        4'b1001, 4'b1010, 4'b1011: cls = C_I;
        4'b1100:                   cls = C_LW;
        4'b1101:                   cls = C_SW;
        4'b1110:                   cls = C_J;
        4'b1111:                   cls = C_BEQ;
        default:                   cls = C_ILL;
      endcase
    end
    return cls;
  endfunction

  assign in_cls = classify(OPCODE);
  assign op_cls = classify(op_q);
  assign State  = state;

  // The limit cycle is the one after MEM_TIMEOUT consecutive idle cycles; a
  // MemReady arriving in that same cycle still completes the access.
  assign timeout = ((state == S_FETCH) || (state == S_MEM)) && !MemReady &&
                   (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      // The counter is cleared unless a wait state explicitly keeps counting.
      wait_cnt <= '0;
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (MemReady)      state    <= S_DECODE;
          else if (!timeout) wait_cnt <= wait_cnt + WAIT_W'(1);
          // A fetch timeout stays in FETCH with a cleared counter (retry).
        end
        S_DECODE: begin
          op_q  <= OPCODE;
          state <= (in_cls == C_ILL) ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          case (op_cls)
            C_R, C_I:   state <= S_WB;
            C_LW, C_SW: state <= S_MEM;
            default:    state <= S_FETCH;  // BEQ and J finish here
          endcase
        end
        S_MEM: begin
          if (MemReady)     state    <= (op_cls == C_LW) ? S_WB : S_FETCH;
          else if (timeout) state    <= S_FETCH;  // instruction discarded
          else              wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_WB:    state <= S_FETCH;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case, so no path through
  // this block can leave a signal unassigned and infer a latch.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    Jump       = 1'b0;
    Branch     = 1'b0;
    MemRead    = 1'b0;
    MemToReg   = 1'b0;
    MemWrite   = 1'b0;
    ALUsrc     = 1'b0;
    RegWrite   = 1'b0;
    ALUop      = ALUOP_W'(2'b00);
    IllegalOp  = 1'b0;
    MemTimeout = timeout;
    case (state)
      S_FETCH: begin
        MemRead = !timeout;  // strobe drops for the abort cycle
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: IllegalOp = (in_cls == C_ILL);
      S_EXEC: begin
        case (op_cls)
          C_R: ALUop = ALUOP_W'(2'b10);
          C_I: begin
            ALUop  = ALUOP_W'(2'b11);
            ALUsrc = 1'b1;
          end
          C_LW, C_SW: ALUsrc = 1'b1;
          C_BEQ: begin
            Branch  = 1'b1;
            ALUop   = ALUOP_W'(2'b01);
            PCWrite = Zero;
          end
          C_J: begin
            Jump    = 1'b1;
            PCWrite = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ALUsrc   = 1'b1;
        MemRead  = (op_cls == C_LW) && !timeout;
        MemWrite = (op_cls == C_SW) && !timeout;
      end
      S_WB: begin
        RegWrite = 1'b1;
        RegDst   = (op_cls == C_R);
        MemToReg = (op_cls == C_LW);
      end
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic retire;

  // Last cycle of each successfully completed instruction.
  assign retire = (state == S_WB) ||
                  ((state == S_MEM) && MemReady && (op_cls == C_SW)) ||
                  ((state == S_EXEC) && ((op_cls == C_J) || (op_cls == C_BEQ)));

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)     InstrCount <= '0;
    else if (retire) InstrCount <= InstrCount + CNT_W'(1);  // wraps naturally
  end
`endif

endmodule

// File: tb/tb_multicycle_cu.sv
// ---------------------------------------------------------------------------
// tb_multicycle_cu -- self-checking bench for multicycle_cu.
//
// Each instruction is described by opcode, Zero value and the number of
// idle MemReady cycles seen in FETCH and MEM. From that description the bench
// expands the expected per-cycle control bundle straight from the instruction
// rules, drives the inputs (randomising everything the DUT should ignore) and
// compares every cycle. Directed cases cover the test-plan items; a random
// instruction mix follows. With PERF_CNT_EN defined, InstrCount is also
// tracked against a retire counter.
// ---------------------------------------------------------------------------
module tb_multicycle_cu;

  localparam int MEM_TIMEOUT = 15;

  typedef enum int { K_R, K_I, K_LW, K_SW, K_J, K_BEQ, K_ILL } kind_t;

  // Field order matches the concatenation in observed().
  typedef struct packed {
    logic [2:0] state;
    logic       pc_write;
    logic       ir_write;
    logic       reg_dst;
    logic       jump;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal;
    logic       timeout;
  } ctl_t;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b0;
  logic [3:0] OPCODE = '0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, IRWrite, RegDst, Jump, Branch, MemRead, MemToReg;
  logic       MemWrite, ALUsrc, RegWrite, IllegalOp, MemTimeout;
  logic [1:0] ALUop;
  logic [2:0] State;
`ifdef PERF_CNT_EN
  logic [15:0] InstrCount;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = '0;

  multicycle_cu #(
    .OPCODE_W(4),
    .ALUOP_W(2),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .Clock(Clock),
    .ResetN(ResetN),
    .OPCODE(OPCODE),
    .Zero(Zero),
    .MemReady(MemReady),
    .PCWrite(PCWrite),
    .IRWrite(IRWrite),
    .RegDst(RegDst),
    .Jump(Jump),
    .Branch(Branch),
    .MemRead(MemRead),
    .MemToReg(MemToReg),
    .MemWrite(MemWrite),
    .ALUsrc(ALUsrc),
    .RegWrite(RegWrite),
    .ALUop(ALUop),
    .State(State),
    .IllegalOp(IllegalOp),
    .MemTimeout(MemTimeout)
`ifdef PERF_CNT_EN
    ,
    .InstrCount(InstrCount)
`endif
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic ctl_t observed();
    return {State, PCWrite, IRWrite, RegDst, Jump, Branch, MemRead, MemToReg,
            MemWrite, ALUsrc, RegWrite, ALUop, IllegalOp, MemTimeout};
  endfunction

  function automatic kind_t kind_of(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010: return K_R;
      4'b1001, 4'b1010, 4'b1011: return K_I;
      4'b1100:                   return K_LW;
      4'b1101:                   return K_SW;
      4'b1110:                   return K_J;
      4'b1111:                   return K_BEQ;
      default:                   return K_ILL;
    endcase
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom);
  endfunction

  function automatic logic [3:0] rnd_op();
    return 4'($urandom);
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare shortly
  // after, well before the next rising edge.
  task automatic cycle(input ctl_t e, input logic rdy, input logic [3:0] op,
                       input logic z, input string tag, input logic ret);
    @(negedge Clock);
    MemReady = rdy;
    OPCODE   = op;
    Zero     = z;
    #1;
    check(tag, {15'd0, observed()}, {15'd0, e});
`ifdef PERF_CNT_EN
    check({tag, "_cnt"}, {16'd0, InstrCount}, {16'd0, exp_cnt});
`endif
    if (ret) exp_cnt = exp_cnt + 16'd1;
  endtask

  // Releases reset just after a rising edge so the following cycle is the
  // single IDLE cycle.
  task automatic release_reset();
    @(posedge Clock);
    #1;
    ResetN = 1'b1;
    cycle('0, rnd_bit(), rnd_op(), rnd_bit(), "idle", 1'b0);
  endtask

  // Asynchronous reset pulse while a store is waiting in MEM.
  task automatic reset_in_mem();
    ctl_t e;
    @(posedge Clock);
    #2;
    e = '0;
    e.state     = 3'd4;
    e.alu_src   = 1'b1;
    e.mem_write = 1'b1;
    check("pre_reset_mem", {15'd0, observed()}, {15'd0, e});
    ResetN = 1'b0;
    #1;
    check("async_reset_outputs", {15'd0, observed()}, 32'd0);
`ifdef PERF_CNT_EN
    check("async_reset_cnt", {16'd0, InstrCount}, 32'd0);
`endif
    exp_cnt = '0;
    for (int i = 0; i < 2; i++) cycle('0, rnd_bit(), rnd_op(), rnd_bit(), "reset_hold", 1'b0);
    release_reset();
  endtask

  // Expands one instruction into its expected cycle sequence and runs it.
  // fw / mw: idle MemReady cycles before completion in FETCH / MEM.
  // rst_at: MEM wait index at which an async reset is pulsed (-1 = never).
  task automatic run_instr(input logic [3:0] op, input logic z, input int fw,
                           input int mw, input int rst_at);
    ctl_t  e;
    int    n;
    kind_t k;
    k = kind_of(op);

    n = 0;
    for (int i = 0; i < fw; i++) begin
      e = '0;
      e.state = 3'd1;
      if (n == MEM_TIMEOUT) begin
        e.timeout = 1'b1;
        n = 0;
      end else begin
        e.mem_read = 1'b1;
        n++;
      end
      cycle(e, 1'b0, rnd_op(), rnd_bit(), e.timeout ? "fetch_timeout" : "fetch_wait", 1'b0);
    end
    e = '0;
    e.state    = 3'd1;
    e.mem_read = 1'b1;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    cycle(e, 1'b1, rnd_op(), rnd_bit(), "fetch_done", 1'b0);

    e = '0;
    e.state   = 3'd2;
    e.illegal = (k == K_ILL);
    cycle(e, rnd_bit(), op, rnd_bit(), $sformatf("decode_op%0h", op), 1'b0);
    if (k == K_ILL) return;

    e = '0;
    e.state = 3'd3;
    case (k)
      K_R:        e.alu_op = 2'b10;
      K_I:        begin e.alu_op = 2'b11; e.alu_src = 1'b1; end
      K_LW, K_SW: e.alu_src = 1'b1;
      K_BEQ:      begin e.branch = 1'b1; e.alu_op = 2'b01; e.pc_write = z; end
      K_J:        begin e.jump = 1'b1; e.pc_write = 1'b1; end
      default:    ;
    endcase
    cycle(e, rnd_bit(), rnd_op(), z, $sformatf("exec_op%0h", op),
          (k == K_BEQ) || (k == K_J));
    if ((k == K_BEQ) || (k == K_J)) return;

    if ((k == K_LW) || (k == K_SW)) begin
      n = 0;
      for (int i = 0; i < mw; i++) begin
        if (i == rst_at) begin
          reset_in_mem();
          return;
        end
        e = '0;
        e.state   = 3'd4;
        e.alu_src = 1'b1;
        if (n == MEM_TIMEOUT) begin
          e.timeout = 1'b1;
          cycle(e, 1'b0, rnd_op(), rnd_bit(), "mem_timeout", 1'b0);
          return;
        end
        e.mem_read  = (k == K_LW);
        e.mem_write = (k == K_SW);
        n++;
        cycle(e, 1'b0, rnd_op(), rnd_bit(), "mem_wait", 1'b0);
      end
      e = '0;
      e.state     = 3'd4;
      e.alu_src   = 1'b1;
      e.mem_read  = (k == K_LW);
      e.mem_write = (k == K_SW);
      cycle(e, 1'b1, rnd_op(), rnd_bit(), "mem_done", k == K_SW);
      if (k == K_SW) return;
    end

    e = '0;
    e.state      = 3'd5;
    e.reg_write  = 1'b1;
    e.reg_dst    = (k == K_R);
    e.mem_to_reg = (k == K_LW);
    cycle(e, rnd_bit(), rnd_op(), rnd_bit(), $sformatf("wb_op%0h", op), 1'b1);
  endtask

  function automatic int rnd_waits();
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 3));
    return int'($urandom_range(13, 17));
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) cycle('0, rnd_bit(), rnd_op(), rnd_bit(), "reset_state", 1'b0);
    release_reset();

    run_instr(4'b0001, 1'b0, 0, 0, -1);   // ADD, no stalls
    run_instr(4'b0001, 1'b1, 0, 0, -1);
    run_instr(4'b1100, 1'b0, 0, 3, -1);   // LW, 3 idle cycles in MEM
    run_instr(4'b1111, 1'b1, 0, 0, -1);   // BEQ taken
    run_instr(4'b1111, 1'b0, 0, 0, -1);   // BEQ not taken
    run_instr(4'b0101, 1'b0, 0, 0, -1);   // illegal
    run_instr(4'b1101, 1'b0, 0, 16, -1);  // SW times out
    run_instr(4'b1101, 1'b0, 0, 15, -1);  // SW completes on the limit cycle
    run_instr(4'b1100, 1'b0, 0, 16, -1);  // LW times out
    run_instr(4'b0010, 1'b0, 17, 0, -1);  // fetch timeout then retry
    run_instr(4'b1010, 1'b0, 15, 0, -1);  // fetch completes on the limit cycle
    run_instr(4'b1110, 1'b0, 2, 0, -1);   // J
    run_instr(4'b1011, 1'b0, 1, 0, -1);   // SLTI

    for (int i = 0; i < 250; i++)
      run_instr(rnd_op(), rnd_bit(), rnd_waits(), rnd_waits(), -1);

    run_instr(4'b1101, 1'b0, 0, 6, 2);    // SW with reset pulse in MEM

    for (int i = 0; i < 3; i++) run_instr(4'b0001, rnd_bit(), 0, 0, -1);
`ifdef PERF_CNT_EN
    @(posedge Clock);
    #1;
    check("cnt_after_3_adds", {16'd0, InstrCount}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multi-cycle control unit for the 16-bit CPU; next generation of the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Stalls on a memory ready handshake and times out hung accesses.
- Drives PC/IR write enables plus the datapath controls (RegDst, ALUsrc, ALUop, ...) per state and latched opcode.

Parameters:
- OPCODE_W, 4, opcode field width; the opcode table below uses the low 4 bits, upper bits must be 0 or the opcode is illegal.
- ALUOP_W, 2, ALUop width.
- MEM_TIMEOUT, 15, max cycles waiting for MemReady in FETCH or MEM before abort (>=1).
- CNT_W, 16, instruction counter width (optional feature only).

Ports:
- Clock  in  1  single clock, rising edge.
- ResetN  in  1  asynchronous, active-low reset.
- OPCODE  in  OPCODE_W  opcode from instruction register; sampled in DECODE.
- Zero  in  1  ALU zero flag, used in EXEC for BEQ.
- MemReady  in  1  memory access completes this cycle.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  instruction register load.
- RegDst, Jump, Branch, MemRead, MemToReg, MemWrite, ALUsrc, RegWrite  out  1 each  datapath controls.
- ALUop  out  ALUOP_W  ALU class: 00 add, 01 sub/compare, 10 R-type funct, 11 immediate.
- State  out  3  current state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5.
- IllegalOp  out  1  one-cycle pulse, undefined opcode.
- MemTimeout  out  1  one-cycle pulse, access aborted.

Behaviour:
- Reset (async, ResetN=0): state=IDLE, latched opcode=0, wait counter=0, all outputs 0. IDLE lasts exactly one cycle after release, then FETCH.
- Outputs are Moore: combinational from state register and latched opcode only. Every output not listed for a state is 0. ALUsrc is never X.
- Opcode classes:
  - RL 0000, RA 0001, SH 0010: R-type.
  - ADDI 1001, SUBI 1010, SLTI 1011: I-type.
  - LW 1100, SW 1101, J 1110, BEQ 1111.
  - All others are illegal.
- FETCH: MemRead=1, ALUop=00.
  - MemReady=1: IRWrite=1, PCWrite=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch OPCODE.
  - Illegal opcode: IllegalOp=1 this cycle, go to FETCH (instruction skipped).
  - Otherwise go to EXEC.
- EXEC, 1 cycle:
  - R-type: ALUop=10, ALUsrc=0, go to WB.
  - I-type: ALUop=11, ALUsrc=1, go to WB.
  - LW/SW: ALUop=00, ALUsrc=1, go to MEM.
  - BEQ: Branch=1, ALUop=01, ALUsrc=0, PCWrite=Zero, go to FETCH.
  - J: Jump=1, PCWrite=1, go to FETCH.
- MEM: ALUsrc=1, ALUop=00.
  - LW: MemRead=1.
  - SW: MemWrite=1.
  - Controls held until MemReady=1; then LW goes to WB, SW goes to FETCH.
- WB, 1 cycle: RegWrite=1.
  - R-type: RegDst=1.
  - LW: MemToReg=1.
  - I-type: RegDst=0, MemToReg=0.
  - Then go to FETCH.
- Wait counter:
  - Clears on every state change. Increments each cycle in FETCH/MEM while MemReady=0.
  - If it reaches MEM_TIMEOUT with MemReady=0: MemTimeout=1 for that cycle, counter clears, memory strobes drop for one cycle (retry), next state is FETCH.
  - MEM abort: no RegWrite, instruction discarded.
  - FETCH abort: fetch restarts, PC unchanged.
  - MemReady=1 on the same cycle as the limit: completion wins, no MemTimeout.
- Reset asserted mid-instruction: immediate return to IDLE; no partial write strobes after the reset edge.

Optional Feature:
- PERF_CNT_EN:
  - Defined: adds output InstrCount [CNT_W-1:0], reset 0. It increments by 1 on each retire (leaving WB, SW MEM completion, or EXEC for BEQ/J) and wraps from all-ones to 0. Illegal and aborted instructions are not counted.
  - Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, MemReady=1 constant, ADD (0001): State 0,1,2,3,5,1 on consecutive cycles; RegWrite=1 and RegDst=1 only in the WB cycle; 4 cycles per instruction.
- LW (1100), MemReady low for 3 cycles in MEM: MEM lasts 4 cycles with MemRead=1 throughout, then WB with MemToReg=1 and RegWrite=1.
- BEQ (1111) with Zero=1, then Zero=0: PCWrite=1, Branch=1, ALUop=01 in EXEC for the first; PCWrite=0 for the second; both return to FETCH, no RegWrite.
- Opcode 0101: IllegalOp single pulse in DECODE, next State=1, no RegWrite/MemWrite.
- SW with MemReady held 0, MEM_TIMEOUT=15: MemWrite high 15 cycles, MemTimeout pulse, back to FETCH; repeat with MemReady=1 exactly at the limit cycle: no MemTimeout.
- Async ResetN pulse while in MEM for SW: MemWrite drops immediately, State=0, all outputs 0; with PERF_CNT_EN, InstrCount=0 afterwards and counts 3 after three retired ADDs.
